pattern_detector_param: RTL and testbench

Parametrised serial pattern detector: recognises a runtime-programmable bit pattern of 1..MAX_LEN bits in a qualified serial stream. Supports overlapping and non-overlapping match modes and keeps a saturating match counter. It supersedes the fixed-pattern detector FSMs in the serial front end, and its configuration is loaded by the control logic.

---
 rtl/pattern_detector_param_if.sv | 43 ++++
 rtl/pattern_detector_param.sv | 154 +++++++++++++++
 tb/tb_pattern_detector_param.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_detector_param_if.sv
// -----------------------------------------------------------------------------
// pattern_detector_param_if
// Bundles the serial stream, configuration and status signals of the
// parametrised pattern detector.
//   master : drives in_valid/in_bit, cfg_* and clr_count; observes status.
//   slave  : the detector; drives armed, cfg_err, match, match_count.
// Signals:
//   in_valid, in_bit          qualified serial data
//   cfg_load                  one-cycle pulse capturing cfg_pattern/len/overlap
//   cfg_pattern[MAX_LEN]      pattern, bit [len-1] is the first bit received
//   cfg_len[LEN_W]            pattern length (1..MAX_LEN legal)
//   cfg_overlap               1 = overlapping matches
//   clr_count                 synchronous clear of match_count
//   armed, cfg_err, match     status / one-cycle match pulse
//   match_count[CNT_W]        saturating match counter
// -----------------------------------------------------------------------------
interface pattern_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic               in_valid;
  logic               in_bit;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               clr_count;
  logic               armed;
  logic               cfg_err;
  logic               match;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
    input  armed, cfg_err, match, match_count
  );

  modport slave (
    input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
    output armed, cfg_err, match, match_count
  );
endinterface

// File: rtl/pattern_detector_param.sv
// -----------------------------------------------------------------------------
// pattern_detector_param
// Runtime-programmable serial pattern detector (1..MAX_LEN bits) with
// overlapping / non-overlapping match modes and a saturating match counter.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   pattern_detector_param_if.slave (stream, config, status)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module pattern_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  pattern_detector_param_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t             r_state;
  logic [MAX_LEN-1:0] r_pat;
  // Only MAX_LEN-1 history bits are stored: the oldest bit of the MAX_LEN
  // window is the one shifted out when the next bit arrives, so it is never
  // compared and need not be kept.
  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_fill;
  logic               r_ovl;
  logic               r_armed;
  logic               r_cfg_err;
  logic               r_match;
  logic [CNT_W-1:0]   r_count;

  logic [MAX_LEN-1:0] w_hist_next;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_fill_next;
  logic               w_cfg_legal;
  logic               w_shift;
  logic               w_hit;
  logic               w_cnt_full;

  // Mask selecting the low 'len' bits; bits above len-1 are don't-care.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len)) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  // Next-history view, saturating fill, config legality and hit detection.
  always_comb begin
    w_hist_next = {r_hist, bus.in_bit};
    w_mask      = len_mask(r_len);
    if (r_fill < r_len) begin
      w_fill_next = r_fill + LEN_W'(1);
    end else begin
      w_fill_next = r_len;
    end
    w_cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
    // A bit arriving with cfg_load is ignored: the history is being cleared.
    w_shift     = (r_state == ST_ARMED) && bus.in_valid && !bus.cfg_load;
    w_hit       = w_shift && (w_fill_next == r_len) &&
                  (((w_hist_next ^ r_pat) & w_mask) == '0);
    w_cnt_full  = (r_count == {CNT_W{1'b1}});
  end

  // Control FSM, configuration capture, history/fill, match pulse and counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_pat     <= '0;
      r_hist    <= '0;
      r_len     <= '0;
      r_fill    <= '0;
      r_ovl     <= 1'b0;
      r_armed   <= 1'b0;
      r_cfg_err <= 1'b0;
      r_match   <= 1'b0;
      r_count   <= '0;
    end else begin
      r_match <= w_hit;

      // Clear wins over a same-cycle increment; the match pulse is unaffected.
      if (bus.clr_count) begin
        r_count <= '0;
      end else if (w_hit && !w_cnt_full) begin
        r_count <= r_count + CNT_W'(1);
      end else begin
        r_count <= r_count;
      end

      if (bus.cfg_load) begin
        r_pat  <= bus.cfg_pattern;
        r_len  <= bus.cfg_len;
        r_ovl  <= bus.cfg_overlap;
        r_hist <= '0;
        r_fill <= '0;
        if (w_cfg_legal) begin
          r_state   <= ST_ARMED;
          r_armed   <= 1'b1;
          r_cfg_err <= 1'b0;
        end else begin
          r_state   <= ST_IDLE;
          r_armed   <= 1'b0;
          r_cfg_err <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
          end
          ST_ARMED: begin
            r_armed <= 1'b1;
            if (bus.in_valid) begin
              r_hist <= w_hist_next[MAX_LEN-2:0];
              // Non-overlap restarts the fill so the next match needs len fresh bits.
              if (w_hit && !r_ovl) begin
                r_fill <= '0;
              end else begin
                r_fill <= w_fill_next;
              end
            end else begin
              r_hist <= r_hist;
              r_fill <= r_fill;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.armed       = r_armed;
  assign bus.cfg_err     = r_cfg_err;
  assign bus.match       = r_match;
  assign bus.match_count = r_count;

endmodule

// File: tb/tb_pattern_detector_param.sv
module tb_pattern_detector_param;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;

  pattern_detector_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

  pattern_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             match;
    logic [CNT_W-1:0] count;
    logic             armed;
    logic             err;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: full received-bit list, bits since last restart.
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  logic               m_ovl;
  logic               m_armed;
  logic               m_err;
  logic               m_bits[$];
  int                 m_since;
  int                 m_count;

  task automatic model_reset();
    m_pat = '0; m_len = 0; m_ovl = 1'b0; m_armed = 1'b0; m_err = 1'b0;
    m_bits.delete(); m_since = 0; m_count = 0;
    sb_q.delete();
  endtask

  // Drive one cycle, push the model's expectation, then score the DUT after the edge.
  task automatic drive_cycle(input logic v, input logic b, input logic ld,
                             input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                             input logic ovl, input logic clr);
    exp_t e;
    logic hit;
    bus.in_valid = v; bus.in_bit = b; bus.cfg_load = ld; bus.cfg_pattern = pat;
    bus.cfg_len = len; bus.cfg_overlap = ovl; bus.clr_count = clr;
    hit = 1'b0;
    if (ld) begin
      m_pat = pat; m_len = int'(len); m_ovl = ovl; m_bits.delete(); m_since = 0;
      m_armed = (m_len >= 1) && (m_len <= MAX_LEN);
      m_err = !m_armed;
    end else if (m_armed && v) begin
      m_bits.push_back(b);
      m_since++;
      if (m_since >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++) begin
          if (m_bits[m_bits.size() - 1 - k] !== m_pat[k]) hit = 1'b0;
        end
      end
      if (hit && !m_ovl) m_since = 0;
    end
    if (clr) m_count = 0;
    else if (hit && m_count < CNT_MAX) m_count++;
    e.match = hit; e.count = CNT_W'(m_count); e.armed = m_armed; e.err = m_err;
    sb_q.push_back(e);

    @(posedge clk); #1;
    bus.cfg_load = 1'b0; bus.clr_count = 1'b0; bus.in_valid = 1'b0;
    e = sb_q.pop_front();
    n_checks++;
    if (bus.match !== e.match) begin
      n_fail++; $display("FAIL sb_match t=%0t: got %b expected %b", $time, bus.match, e.match);
    end
    n_checks++;
    if (bus.match_count !== e.count) begin
      n_fail++; $display("FAIL sb_count t=%0t: got %0d expected %0d", $time, bus.match_count, e.count);
    end
    n_checks++;
    if (bus.armed !== e.armed || bus.cfg_err !== e.err) begin
      n_fail++; $display("FAIL sb_status t=%0t: got armed=%b err=%b expected armed=%b err=%b",
                         $time, bus.armed, bus.cfg_err, e.armed, e.err);
    end
  endtask

  task automatic bit_in(input logic b);
    drive_cycle(1'b1, b, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic cfg(input logic [MAX_LEN-1:0] pat, input int len, input logic ovl);
    drive_cycle(1'b0, 1'b0, 1'b1, pat, LEN_W'(len), ovl, 1'b1);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.armed !== 1'b0 || bus.cfg_err !== 1'b0 || bus.match !== 1'b0 || bus.match_count !== 4'd0) begin
      n_fail++; $display("FAIL reset_state: got armed=%b err=%b match=%b cnt=%0d expected all 0",
                         bus.armed, bus.cfg_err, bus.match, bus.match_count);
    end
    #2 rst = 1'b1;
  endtask

  task automatic test_overlap(input logic ovl, input logic [6:0] exp_pulses, input int exp_cnt);
    logic [6:0] stream;
    logic [6:0] got;
    stream = 7'b1011011;
    got = '0;
    cfg(8'b0000_1011, 4, ovl);
    for (int i = 0; i < 7; i++) begin
      bit_in(stream[6-i]);
      got[6-i] = bus.match;
    end
    n_checks++;
    if (got !== exp_pulses) begin
      n_fail++; $display("FAIL overlap%0b_pulses: got %b expected %b", ovl, got, exp_pulses);
    end
    n_checks++;
    if (bus.match_count !== CNT_W'(exp_cnt)) begin
      n_fail++; $display("FAIL overlap%0b_count: got %0d expected %0d", ovl, bus.match_count, exp_cnt);
    end
  endtask

  task automatic test_gap();
    logic [2:0] bits;
    int gap_pulses;
    bits = 3'b101;
    gap_pulses = 0;
    cfg(8'b0000_0101, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bit_in(bits[2-i]);
      if (i < 2) begin
        repeat (3) begin
          idle();
          if (bus.match !== 1'b0) gap_pulses++;
        end
      end
    end
    n_checks++;
    if (bus.match !== 1'b1) begin
      n_fail++; $display("FAIL gap_final_match: got %b expected 1", bus.match);
    end
    idle();
    n_checks++;
    if (gap_pulses != 0 || bus.match !== 1'b0) begin
      n_fail++; $display("FAIL gap_no_extra: got gap_pulses=%0d match=%b expected 0 and 0", gap_pulses, bus.match);
    end
  endtask

  task automatic test_cfg_err();
    int pulses;
    cfg(8'hFF, 0, 1'b1);
    n_checks++;
    if (bus.armed !== 1'b0 || bus.cfg_err !== 1'b1) begin
      n_fail++; $display("FAIL cfg_len0: got armed=%b err=%b expected 0 1", bus.armed, bus.cfg_err);
    end
    pulses = 0;
    repeat (4) begin bit_in(1'b1); if (bus.match === 1'b1) pulses++; end
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL cfg_err_nomatch: got %0d pulses expected 0", pulses);
    end
    cfg(8'hFF, MAX_LEN + 1, 1'b1);
    n_checks++;
    if (bus.armed !== 1'b0 || bus.cfg_err !== 1'b1) begin
      n_fail++; $display("FAIL cfg_len_over: got armed=%b err=%b expected 0 1", bus.armed, bus.cfg_err);
    end
    cfg(8'hFF, MAX_LEN, 1'b1);
    n_checks++;
    if (bus.armed !== 1'b1 || bus.cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL cfg_len_max: got armed=%b err=%b expected 1 0", bus.armed, bus.cfg_err);
    end
    pulses = 0;
    repeat (MAX_LEN) begin bit_in(1'b1); if (bus.match === 1'b1) pulses++; end
    n_checks++;
    if (pulses != 1 || bus.match !== 1'b1) begin
      n_fail++; $display("FAIL cfg_max_match: got %0d pulses last=%b expected 1 and 1", pulses, bus.match);
    end
  endtask

  task automatic test_reload();
    cfg(8'b0000_0011, 2, 1'b1);
    bit_in(1'b1);
    drive_cycle(1'b1, 1'b1, 1'b1, 8'b0000_0011, LEN_W'(2), 1'b1, 1'b0);
    n_checks++;
    if (bus.match !== 1'b0) begin
      n_fail++; $display("FAIL reload_ignored: got match=%b expected 0", bus.match);
    end
    bit_in(1'b1);
    n_checks++;
    if (bus.match !== 1'b0) begin
      n_fail++; $display("FAIL reload_first: got match=%b expected 0", bus.match);
    end
    bit_in(1'b1);
    n_checks++;
    if (bus.match !== 1'b1) begin
      n_fail++; $display("FAIL reload_second: got match=%b expected 1", bus.match);
    end
  endtask

  task automatic test_saturation();
    cfg(8'b0000_0001, 1, 1'b0);
    repeat (20) bit_in(1'b1);
    n_checks++;
    if (bus.match_count !== 4'd15) begin
      n_fail++; $display("FAIL sat_count: got %0d expected 15", bus.match_count);
    end
    bit_in(1'b0);
    n_checks++;
    if (bus.match !== 1'b0 || bus.match_count !== 4'd15) begin
      n_fail++; $display("FAIL len1_zero: got match=%b cnt=%0d expected 0 15", bus.match, bus.match_count);
    end
    drive_cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    n_checks++;
    if (bus.match !== 1'b1 || bus.match_count !== 4'd0) begin
      n_fail++; $display("FAIL clr_with_hit: got match=%b cnt=%0d expected 1 0", bus.match, bus.match_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] got;
    got = '0;
    cfg(8'b0000_0011, 2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bit_in(1'b1);
      got[3-i] = bus.match;
    end
    n_checks++;
    if (got !== 4'b0111 || bus.match_count !== 4'd3) begin
      n_fail++; $display("FAIL back_to_back: got pulses=%b cnt=%0d expected 0111 3", got, bus.match_count);
    end
  endtask

  task automatic test_async_reset();
    int pulses;
    cfg(8'b0000_0011, 2, 1'b1);
    bit_in(1'b1);
    bit_in(1'b1);
    n_checks++;
    if (bus.match !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre: got match=%b expected 1", bus.match);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.armed !== 1'b0 || bus.cfg_err !== 1'b0 || bus.match !== 1'b0 || bus.match_count !== 4'd0) begin
      n_fail++; $display("FAIL areset_async: got armed=%b err=%b match=%b cnt=%0d expected all 0",
                         bus.armed, bus.cfg_err, bus.match, bus.match_count);
    end
    model_reset();
    #2 rst = 1'b1;
    pulses = 0;
    repeat (3) begin bit_in(1'b1); if (bus.match === 1'b1) pulses++; end
    n_checks++;
    if (pulses != 0 || bus.armed !== 1'b0) begin
      n_fail++; $display("FAIL areset_unarmed: got %0d pulses armed=%b expected 0 0", pulses, bus.armed);
    end
    cfg(8'b0000_0011, 2, 1'b1);
    bit_in(1'b1);
    bit_in(1'b1);
    n_checks++;
    if (bus.match !== 1'b1) begin
      n_fail++; $display("FAIL areset_recfg: got match=%b expected 1", bus.match);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.cfg_load = 1'b0; bus.cfg_pattern = '0;
    bus.cfg_len = '0; bus.cfg_overlap = 1'b0; bus.clr_count = 1'b0;
    model_reset();
    test_reset();
    test_overlap(1'b1, 7'b0001001, 2);
    test_overlap(1'b0, 7'b0001000, 1);
    test_gap();
    test_cfg_err();
    test_reload();
    test_saturation();
    test_back_to_back();
    test_async_reset();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
